// File: rtl/scope_seq_pkg.sv
// scope_seq_pkg: shared types and constants for the multi-segment acquisition
// sequencer. Holds the sequencer state encoding and the bit positions of the
// acquire-handler control strobes within the internal strobe vector.
package scope_seq_pkg;

    // Sequencer states, in the order a segment normally walks through them
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_ARM  = 3'd2,
        ST_WTRG = 3'd3,
        ST_WSTP = 3'd4,
        ST_HOLD = 3'd5
    } seq_state_t;

    // Bit positions of the acquire-handler strobes in the strobe vector
    localparam int STB_RST = 0;
    localparam int STB_ACQ = 1;
    localparam int STB_STP = 2;
    localparam int STB_W   = 3;

    // One-hot strobe vector with only the requested strobe set, so at most
    // one control strobe can ever be issued per cycle
    function automatic logic [STB_W-1:0] stb_bit(input int idx);
        return STB_W'(1) << idx;
    endfunction

endpackage

// File: rtl/scope_seq_tmr.sv
// scope_seq_tmr: loadable down-counter used for the hold-off interval and the
// per-segment trigger timeout. A load takes priority over counting; counting
// stops at zero so 'zero' stays asserted until the next load.
module scope_seq_tmr #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] cnt_reg;

    // Load, or count down while enabled and not yet exhausted
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/scope_seq.sv
// scope_seq: multi-segment acquisition sequencer. Drives the acquire handler's
// reset/start/stop strobes, captures cfg_seg triggered segments back to back
// with a hold-off between them, and handles abort and buffer back-pressure.
// Optional feature macro: SCOPE_SEQ_TMO_EN builds the per-segment trigger
// timeout; without it cfg_tmo is ignored and sts_tmo is constant 0.
module scope_seq #(
    parameter int CW = 32,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ctl_str,
    input  logic          ctl_abt,
    input  logic [SW-1:0] cfg_seg,
    input  logic [CW-1:0] cfg_hld,
    input  logic [CW-1:0] cfg_tmo,
    input  logic          buf_rdy,
    input  logic          irq_trg,
    input  logic          irq_stp,
    output logic          acq_rst,
    output logic          acq_acq,
    output logic          acq_stp,
    output logic          sts_bsy,
    output logic [SW-1:0] sts_cnt,
    output logic          sts_tmo,
    output logic          sts_abt,
    output logic          irq_don
);

    import scope_seq_pkg::*;

    seq_state_t       state_reg;
    logic [STB_W-1:0] stb_reg;
    logic             bsy_reg;
    logic             abt_reg;
    logic             don_reg;
    logic [SW-1:0]    cnt_reg;

    logic             abort_ev;
    logic             start_ev;
    logic             arm_ev;
    logic             stop_ev;
    logic             tmo_ev;
    logic             last_seg;
    logic [SW-1:0]    cnt_next;

    logic             hld_load;
    logic             hld_en;
    logic             hld_zero;

    // Abort only matters while a sequence runs, and it masks every other
    // event of the same cycle (including a coincident stop).
    assign abort_ev = ctl_abt && (state_reg != ST_IDLE);

    // A start that coincides with an abort is dropped.
    assign start_ev = (state_reg == ST_IDLE) && ctl_str && !ctl_abt;

    // Arming is evaluated in RST and at the end of HOLD as well as in ARM, so
    // acq_acq follows the reset strobe or the hold-off immediately when the
    // buffer already has room.
    assign arm_ev = !abort_ev && buf_rdy &&
                    ((state_reg == ST_RST) || (state_reg == ST_ARM) ||
                     ((state_reg == ST_HOLD) && hld_zero));

    // A stop counts in WSTP, or in WTRG when it arrives with the trigger.
    assign stop_ev = !abort_ev && irq_stp &&
                     ((state_reg == ST_WSTP) ||
                      ((state_reg == ST_WTRG) && irq_trg));

    // Segment count wraps naturally; cfg_seg = 0 never matches a compare.
    assign cnt_next = cnt_reg + SW'(1);
    assign last_seg = (cfg_seg != '0) && (cnt_next == cfg_seg);

    assign hld_load = stop_ev && !last_seg;
    assign hld_en   = (state_reg == ST_HOLD);

    scope_seq_tmr #(
        .CW(CW)
    ) u_hld_tmr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (hld_load),
        .load_val (cfg_hld),
        .en       (hld_en),
        .zero     (hld_zero)
    );

`ifdef SCOPE_SEQ_TMO_EN
    logic tmo_en;
    logic tmo_zero;
    logic tmo_act_reg;
    logic tmo_sts_reg;

    assign tmo_en = (state_reg == ST_WTRG);

    scope_seq_tmr #(
        .CW(CW)
    ) u_tmo_tmr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (arm_ev),
        .load_val (cfg_tmo),
        .en       (tmo_en),
        .zero     (tmo_zero)
    );

    // A trigger in the expiry cycle wins over the timeout.
    assign tmo_ev = !abort_ev && (state_reg == ST_WTRG) && !irq_trg &&
                    tmo_act_reg && tmo_zero;

    // Capture at arm time whether this segment has a timeout; keep the sticky
    // timeout flag until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_act_reg <= 1'b0;
            tmo_sts_reg <= 1'b0;
        end else begin
            if (arm_ev) begin
                tmo_act_reg <= (cfg_tmo != '0);
            end
            if (start_ev) begin
                tmo_sts_reg <= 1'b0;
            end else if (tmo_ev) begin
                tmo_sts_reg <= 1'b1;
            end
        end
    end

    assign sts_tmo = tmo_sts_reg;
`else
    logic unused_cfg_tmo;

    assign unused_cfg_tmo = ^cfg_tmo;
    assign tmo_ev         = 1'b0;
    assign sts_tmo        = 1'b0;
`endif

    // Sequencer state machine with registered strobes and status
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            stb_reg   <= '0;
            bsy_reg   <= 1'b0;
            abt_reg   <= 1'b0;
            don_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            stb_reg <= '0;
            don_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (start_ev) begin
                    cnt_reg   <= '0;
                    abt_reg   <= 1'b0;
                    bsy_reg   <= 1'b1;
                    stb_reg   <= stb_bit(STB_RST);
                    state_reg <= ST_RST;
                end
            end else if (abort_ev) begin
                stb_reg   <= stb_bit(STB_STP);
                abt_reg   <= 1'b1;
                don_reg   <= 1'b1;
                bsy_reg   <= 1'b0;
                state_reg <= ST_IDLE;
            end else if (tmo_ev) begin
                stb_reg   <= stb_bit(STB_STP);
                don_reg   <= 1'b1;
                bsy_reg   <= 1'b0;
                state_reg <= ST_IDLE;
            end else if (stop_ev) begin
                cnt_reg <= cnt_next;
                if (last_seg) begin
                    don_reg   <= 1'b1;
                    bsy_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg <= ST_HOLD;
                end
            end else if (arm_ev) begin
                stb_reg   <= stb_bit(STB_ACQ);
                state_reg <= ST_WTRG;
            end else begin
                case (state_reg)
                    ST_RST:  state_reg <= ST_ARM;
                    ST_WTRG: if (irq_trg) state_reg <= ST_WSTP;
                    ST_HOLD: if (hld_zero) state_reg <= ST_ARM;
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign acq_rst = stb_reg[STB_RST];
    assign acq_acq = stb_reg[STB_ACQ];
    assign acq_stp = stb_reg[STB_STP];
    assign sts_bsy = bsy_reg;
    assign sts_cnt = cnt_reg;
    assign sts_abt = abt_reg;
    assign irq_don = don_reg;

endmodule

// File: tb/tb_scope_seq.sv
// tb_scope_seq: randomized self-checking bench for scope_seq. A behavioural
// acquire-handler responder issues trigger/stop pulses after each arm; the
// expected timing (re-arm, timeout, completion, counts) is derived from the
// sequencer's rules and compared against logged event cycles.
module tb_scope_seq;

    localparam int TB_CW = 16;
    localparam int TB_SW = 4;

    logic             clk;
    logic             rstn;
    logic             ctl_str;
    logic             ctl_abt;
    logic [TB_SW-1:0] cfg_seg;
    logic [TB_CW-1:0] cfg_hld;
    logic [TB_CW-1:0] cfg_tmo;
    logic             buf_rdy;
    logic             irq_trg;
    logic             irq_stp;
    logic             acq_rst;
    logic             acq_acq;
    logic             acq_stp;
    logic             sts_bsy;
    logic [TB_SW-1:0] sts_cnt;
    logic             sts_tmo;
    logic             sts_abt;
    logic             irq_don;

    scope_seq #(
        .CW(TB_CW),
        .SW(TB_SW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ctl_str (ctl_str),
        .ctl_abt (ctl_abt),
        .cfg_seg (cfg_seg),
        .cfg_hld (cfg_hld),
        .cfg_tmo (cfg_tmo),
        .buf_rdy (buf_rdy),
        .irq_trg (irq_trg),
        .irq_stp (irq_stp),
        .acq_rst (acq_rst),
        .acq_acq (acq_acq),
        .acq_stp (acq_stp),
        .sts_bsy (sts_bsy),
        .sts_cnt (sts_cnt),
        .sts_tmo (sts_tmo),
        .sts_abt (sts_abt),
        .irq_don (irq_don)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int str_cyc = 0;
    int acq_q[$];
    int stp_q[$];
    int astp_q[$];
    int don_q[$];
    int rst_q[$];
    int excl_err = 0;

    bit resp_en = 1'b0;
    int trg_at = -1;
    int stp_at = -1;
    int trg_lo = 0;
    int trg_hi = 0;
    int stp_lo = 0;
    int stp_hi = 0;

    int rdy_low_until = 0;
    bit rdy_gap_arm = 1'b0;
    int abort_stop_idx = 0;
    int exp_cnt = 0;
    int cnt_chk_at = -1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    task automatic clear_log();
        acq_q.delete();
        stp_q.delete();
        astp_q.delete();
        don_q.delete();
        rst_q.delete();
        excl_err   = 0;
        exp_cnt    = 0;
        cnt_chk_at = -1;
        trg_at     = -1;
        stp_at     = -1;
    endtask

    // One clock: observe this cycle's outputs, then drive next inputs
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ctl_str = 1'b0;
        ctl_abt = 1'b0;
        irq_trg = 1'b0;
        irq_stp = 1'b0;
        rstn    = 1'b1;
        if (int'(acq_rst) + int'(acq_acq) + int'(acq_stp) > 1) excl_err++;
        if (acq_rst) rst_q.push_back(cyc);
        if (acq_stp) astp_q.push_back(cyc);
        if (irq_don) don_q.push_back(cyc);
        if (cyc == cnt_chk_at) check_eq("seg_cnt", int'(sts_cnt), exp_cnt);
        if (acq_acq) begin
            acq_q.push_back(cyc);
            if (resp_en) begin
                trg_at = cyc + int'($urandom_range(trg_hi, trg_lo));
                stp_at = trg_at + int'($urandom_range(stp_hi, stp_lo));
            end
        end
        if (cyc == trg_at) irq_trg = 1'b1;
        if (cyc == stp_at) begin
            irq_stp = 1'b1;
            stp_q.push_back(cyc);
            if (stp_q.size() == abort_stop_idx) begin
                ctl_abt = 1'b1;
            end else begin
                exp_cnt    = (exp_cnt + 1) % (1 << TB_SW);
                cnt_chk_at = cyc + 1;
            end
            if (rdy_gap_arm) begin
                rdy_gap_arm   = 1'b0;
                rdy_low_until = cyc + 50;
            end
        end
        buf_rdy = (cyc >= rdy_low_until);
    endtask

    task automatic start_seq(input int seg, input int hld, input int tmo);
        clear_log();
        cfg_seg = TB_SW'(seg);
        cfg_hld = TB_CW'(hld);
        cfg_tmo = TB_CW'(tmo);
        ctl_str = 1'b1;
        str_cyc = cyc;
        step();
    endtask

    task automatic wait_don(input int budget);
        for (int k = 0; k < budget && don_q.size() == 0; k++) step();
    endtask

    task automatic do_abort(input string tag);
        resp_en = 1'b0;
        trg_at  = -1;
        stp_at  = -1;
        ctl_abt = 1'b1;
        step();
        check_eq({tag, "_abt_stp"}, int'(acq_stp), 1);
        check_eq({tag, "_abt_don"}, int'(irq_don), 1);
        check_eq({tag, "_abt_sts"}, int'(sts_abt), 1);
        check_eq({tag, "_abt_bsy"}, int'(sts_bsy), 0);
        $display("abort %s: acq_stp=%0d irq_don=%0d sts_abt=%0d cnt=%0d",
                 tag, acq_stp, irq_don, sts_abt, sts_cnt);
    endtask

    // Full sequence with the responder; checks timing against the rules
    task automatic run_normal(input string tag, input int seg, input int hld,
                              input int tmo, input bit use_gap);
        int exp_acq;
        resp_en     = 1'b1;
        rdy_gap_arm = use_gap;
        start_seq(seg, hld, tmo);
        wait_don(3000);
        check_eq({tag, "_don_seen"}, don_q.size(), 1);
        check_eq({tag, "_rst_t"}, q_at(rst_q, 0), str_cyc + 1);
        check_eq({tag, "_acq0_t"}, q_at(acq_q, 0), str_cyc + 2);
        check_eq({tag, "_acq_n"}, acq_q.size(), seg);
        for (int i = 1; i < seg; i++) begin
            if (use_gap && i == 1) exp_acq = rdy_low_until + 1;
            else exp_acq = q_at(stp_q, i - 1) + hld + 2;
            check_eq({tag, "_rearm_t"}, q_at(acq_q, i), exp_acq);
        end
        check_eq({tag, "_don_t"}, q_at(don_q, 0), q_at(stp_q, seg - 1) + 1);
        check_eq({tag, "_cnt"}, int'(sts_cnt), seg % (1 << TB_SW));
        check_eq({tag, "_bsy"}, int'(sts_bsy), 0);
        check_eq({tag, "_tmo"}, int'(sts_tmo), 0);
        check_eq({tag, "_abt"}, int'(sts_abt), 0);
        repeat (4) step();
        check_eq({tag, "_don_once"}, don_q.size(), 1);
        check_eq({tag, "_acq_after"}, acq_q.size(), seg);
        check_eq({tag, "_no_stp"}, astp_q.size(), 0);
        check_eq({tag, "_excl"}, excl_err, 0);
        $display("seq %s: seg=%0d hld=%0d tmo=%0d acq=%0d stops=%0d cnt=%0d",
                 tag, seg, hld, tmo, acq_q.size(), stp_q.size(), sts_cnt);
    endtask

    initial begin
        int t;
        int h;
        rstn    = 1'b0;
        ctl_str = 1'b0;
        ctl_abt = 1'b0;
        cfg_seg = '0;
        cfg_hld = '0;
        cfg_tmo = '0;
        buf_rdy = 1'b1;
        irq_trg = 1'b0;
        irq_stp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_strobes",
                 int'({acq_rst, acq_acq, acq_stp, sts_bsy, sts_tmo, sts_abt, irq_don}), 0);
        check_eq("reset_cnt", int'(sts_cnt), 0);
        rstn = 1'b1;
        step();

        // Planned case: 3 segments, hold-off 4, handler answers 10 cycles after arm
        trg_lo = 10; trg_hi = 10; stp_lo = 0; stp_hi = 3;
        run_normal("plan", 3, 4, 0, 1'b0);

        // Timeout with no trigger at all
        resp_en = 1'b0;
`ifdef SCOPE_SEQ_TMO_EN
        for (int it = 0; it < 2; it++) begin
            t = (it == 0) ? 20 : int'($urandom_range(30, 1));
            start_seq(2, 0, t);
            wait_don(200);
            check_eq("tmo_don_seen", don_q.size(), 1);
            check_eq("tmo_stp_t", q_at(astp_q, 0), q_at(acq_q, 0) + t + 1);
            check_eq("tmo_don_t", q_at(don_q, 0), q_at(astp_q, 0));
            check_eq("tmo_sts", int'(sts_tmo), 1);
            check_eq("tmo_cnt", int'(sts_cnt), 0);
            check_eq("tmo_bsy", int'(sts_bsy), 0);
            check_eq("tmo_acq_n", acq_q.size(), 1);
            $display("seq tmo: tmo=%0d acq_at=%0d stp_at=%0d sts_tmo=%0d",
                     t, q_at(acq_q, 0), q_at(astp_q, 0), sts_tmo);
        end
`else
        start_seq(2, 0, 20);
        repeat (60) step();
        check_eq("notmo_bsy", int'(sts_bsy), 1);
        check_eq("notmo_stp", astp_q.size(), 0);
        check_eq("notmo_don", don_q.size(), 0);
        check_eq("notmo_sts", int'(sts_tmo), 0);
        check_eq("notmo_acq_n", acq_q.size(), 1);
        $display("seq notmo: waited 60 cycles, sts_bsy=%0d", sts_bsy);
        do_abort("notmo");
`endif

        // Randomized sequences; timeout (if built) is longer than any response
        trg_lo = 0; trg_hi = 8; stp_lo = 0; stp_hi = 3;
        for (int it = 0; it < 4; it++) begin
            run_normal("rnd", int'($urandom_range(4, 1)), int'($urandom_range(6, 0)),
                       int'($urandom_range(40, 15)), 1'b0);
        end

        // Buffer not ready for 50 cycles after the first segment
        trg_lo = 2; trg_hi = 5; stp_lo = 0; stp_hi = 2;
        run_normal("bufgap", 2, 2, 0, 1'b1);

        // Continuous mode: 2^SW+2 segments then abort
        trg_lo = 0; trg_hi = 2; stp_lo = 0; stp_hi = 1;
        h = int'($urandom_range(2, 0));
        resp_en = 1'b1;
        start_seq(0, h, 0);
        for (int k = 0; k < 2000 && !(stp_q.size() >= (1 << TB_SW) + 2 && cyc >= cnt_chk_at); k++) step();
        resp_en = 1'b0;
        trg_at  = -1;
        stp_at  = -1;
        check_eq("cont_stops", stp_q.size(), (1 << TB_SW) + 2);
        check_eq("cont_cnt", int'(sts_cnt), 2);
        check_eq("cont_no_don", don_q.size(), 0);
        check_eq("cont_bsy", int'(sts_bsy), 1);
        $display("seq cont: hld=%0d stops=%0d cnt=%0d", h, stp_q.size(), sts_cnt);
        repeat ($urandom_range(3, 0)) step();
        do_abort("cont");

        // Abort coincident with the final stop
        trg_lo = 1; trg_hi = 4; stp_lo = 1; stp_hi = 3;
        resp_en        = 1'b1;
        abort_stop_idx = 2;
        start_seq(2, 1, 0);
        wait_don(500);
        abort_stop_idx = 0;
        resp_en        = 1'b0;
        check_eq("abtstp_don_t", q_at(don_q, 0), q_at(stp_q, 1) + 1);
        check_eq("abtstp_stp_t", q_at(astp_q, 0), q_at(stp_q, 1) + 1);
        check_eq("abtstp_cnt", int'(sts_cnt), 1);
        check_eq("abtstp_sts", int'(sts_abt), 1);
        $display("seq abtstp: stops=%0d cnt=%0d sts_abt=%0d", stp_q.size(), sts_cnt, sts_abt);

        // Start and abort together in IDLE: nothing happens
        clear_log();
        ctl_str = 1'b1;
        ctl_abt = 1'b1;
        repeat (8) step();
        check_eq("stabt_rst", rst_q.size(), 0);
        check_eq("stabt_acq", acq_q.size(), 0);
        check_eq("stabt_bsy", int'(sts_bsy), 0);
        check_eq("stabt_abt", int'(sts_abt), 1);
        check_eq("stabt_cnt", int'(sts_cnt), 1);
        $display("seq stabt: rst=%0d acq=%0d bsy=%0d", rst_q.size(), acq_q.size(), sts_bsy);

        // Reset while waiting for stop, then a clean sequence
        trg_lo = 1; trg_hi = 3; stp_lo = 3; stp_hi = 5;
        resp_en = 1'b1;
        start_seq(3, 1, 0);
        for (int k = 0; k < 200 && !(trg_at >= 0 && cyc == trg_at + 1); k++) step();
        check_eq("rst_reached_wstp", int'(trg_at >= 0 && cyc == trg_at + 1), 1);
        rstn    = 1'b0;
        resp_en = 1'b0;
        trg_at  = -1;
        stp_at  = -1;
        step();
        check_eq("midrst_out",
                 int'({acq_rst, acq_acq, acq_stp, sts_bsy, sts_tmo, sts_abt, irq_don}), 0);
        check_eq("midrst_cnt", int'(sts_cnt), 0);
        repeat (3) step();
        check_eq("midrst_no_stp", astp_q.size(), 0);
        check_eq("midrst_no_don", don_q.size(), 0);
        check_eq("midrst_bsy", int'(sts_bsy), 0);
        $display("seq midrst: outputs after reset bsy=%0d cnt=%0d", sts_bsy, sts_cnt);
        trg_lo = 0; trg_hi = 4; stp_lo = 0; stp_hi = 2;
        run_normal("postrst", 2, 3, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
